writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_if.sv | 28 ++
 rtl/writeback_arbiter.sv | 135 +++++++++++++
 tb/tb_writeback_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Writeback port bundle: primary pipeline request, secondary result queue input,
// and the registered register-file write port.
interface writeback_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  p_write;
  logic [4:0]            p_reg;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  p_stall;
  logic                  s_valid;
  logic [4:0]            s_reg;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  write;
  logic [4:0]            write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  pending;

  modport master (
    output p_write, p_reg, p_data, s_valid, s_reg, s_data,
    input  p_stall, s_ready, write, write_reg, write_data, pending
  );

  modport slave (
    input  p_write, p_reg, p_data, s_valid, s_reg, s_data,
    output p_stall, s_ready, write, write_reg, write_data, pending
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Shares one register-file write port between the pipeline and a queued long-latency unit.
// Define WB_ARB_AGING_EN to force a starved queue head onto the port after AGE_LIMIT cycles.
module writeback_arbiter #(
  parameter int unsigned CORE       = 0,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned AGE_LIMIT  = 4
) (
  input logic                clk,
  input logic                reset,
  writeback_arbiter_if.slave wb
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [1:0] {GntNone, GntPrimary, GntQueue} grant_e;

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [4:0]            reg_mem  [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, count;
  logic [AddrW-1:0]      wr_idx, rd_idx;
  logic                  full, empty, accept, push, pop, p_req, forced;
  grant_e                grant;

  logic                  write_q;
  logic [4:0]            write_reg_q;
  logic [DATA_WIDTH-1:0] write_data_q;

  // Extra pointer bit distinguishes full from empty.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == PtrW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign wr_idx = wr_ptr_q[AddrW-1:0];
  assign rd_idx = rd_ptr_q[AddrW-1:0];

  // Results for x0 are acknowledged but never stored.
  assign accept = wb.s_valid & ~full;
  assign push   = accept & (wb.s_reg != 5'd0);
  assign p_req  = wb.p_write & (wb.p_reg != 5'd0);

`ifdef WB_ARB_AGING_EN
  localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);

  logic [AgeW-1:0] age_q, age_d;

  assign forced = ~empty & (age_q == AgeW'(AGE_LIMIT));

  always_comb begin
    age_d = age_q;
    if (pop) begin
      age_d = '0;
    end else if (!empty) begin
      age_d = age_q + AgeW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    grant = GntNone;
    if (forced) begin
      grant = GntQueue;
    end else if (p_req) begin
      grant = GntPrimary;
    end else if (!empty) begin
      grant = GntQueue;
    end
  end

  assign pop = (grant == GntQueue);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_idx] <= wb.s_data;
      reg_mem[wr_idx]  <= wb.s_reg;
    end
  end

  // Address and data hold their last value on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      write_q <= (grant != GntNone);
      unique case (grant)
        GntPrimary: begin
          write_reg_q  <= wb.p_reg;
          write_data_q <= wb.p_data;
        end
        GntQueue: begin
          write_reg_q  <= reg_mem[rd_idx];
          write_data_q <= data_mem[rd_idx];
        end
        default: ;
      endcase
    end
  end

  assign wb.write      = write_q;
  assign wb.write_reg  = write_reg_q;
  assign wb.write_data = write_data_q;
  assign wb.s_ready    = ~full;
  assign wb.pending    = ~empty;
  assign wb.p_stall    = forced;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full) && AGE_LIMIT > 0)
        else $error("wb_arb core %0d: queue overflow or bad AGE_LIMIT", CORE);
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; follows WB_ARB_AGING_EN for the starvation case.
module tb_writeback_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  writeback_arbiter_if #(.DATA_WIDTH(32)) wb ();

  writeback_arbiter #(
    .CORE       (0),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (2),
    .AGE_LIMIT  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.p_write = 1'b0;
    wb.p_reg   = 5'd0;
    wb.p_data  = '0;
    wb.s_valid = 1'b0;
    wb.s_reg   = 5'd0;
    wb.s_data  = '0;
  endtask

  task automatic check_port(input string tag, input logic w, input logic [4:0] r,
                            input logic [31:0] d);
    check_eq({tag, ".write"}, 32'(wb.write), 32'(w));
    check_eq({tag, ".reg"}, 32'(wb.write_reg), 32'(r));
    check_eq({tag, ".data"}, wb.write_data, d);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    reset = 1'b1;
    tick();
    check_port("rst", 1'b0, 5'd0, 32'h0);
    check_eq("rst.pending", 32'(wb.pending), 32'd0);
    check_eq("rst.s_ready", 32'(wb.s_ready), 32'd1);
    check_eq("rst.p_stall", 32'(wb.p_stall), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle.write", 32'(wb.write), 32'd0);

    // Primary only
    wb.p_write = 1'b1; wb.p_reg = 5'd3; wb.p_data = 32'd5;
    tick();
    idle();
    check_port("prim", 1'b1, 5'd3, 32'd5);
    tick();
    check_port("prim.hold", 1'b0, 5'd3, 32'd5);

    // Secondary only
    wb.s_valid = 1'b1; wb.s_reg = 5'd7; wb.s_data = 32'd9;
    tick();
    idle();
    check_eq("sec.pending", 32'(wb.pending), 32'd1);
    check_eq("sec.nowrite", 32'(wb.write), 32'd0);
    tick();
    check_port("sec", 1'b1, 5'd7, 32'd9);
    check_eq("sec.drained", 32'(wb.pending), 32'd0);

    // p_reg=0 leaves the slot to the queue
    wb.s_valid = 1'b1; wb.s_reg = 5'd4; wb.s_data = 32'h44;
    wb.p_write = 1'b1; wb.p_reg = 5'd0; wb.p_data = 32'hdead;
    tick();
    wb.s_valid = 1'b0;
    check_eq("x0.pending", 32'(wb.pending), 32'd1);
    check_eq("x0.nowrite", 32'(wb.write), 32'd0);
    tick();
    idle();
    check_port("x0.queue", 1'b1, 5'd4, 32'h44);
    check_eq("x0.drained", 32'(wb.pending), 32'd0);
    // s_reg=0 is acknowledged and dropped
    wb.s_valid = 1'b1; wb.s_reg = 5'd0; wb.s_data = 32'h77;
    check_eq("x0.s_ready", 32'(wb.s_ready), 32'd1);
    tick();
    idle();
    check_eq("x0s.pending", 32'(wb.pending), 32'd0);
    check_eq("x0s.write", 32'(wb.write), 32'd0);
    tick();
    check_port("x0s.later", 1'b0, 5'd4, 32'h44);

    // Full queue back-pressure with primary held
    wb.p_write = 1'b1; wb.p_reg = 5'd1; wb.p_data = 32'h100;
    wb.s_valid = 1'b1; wb.s_reg = 5'd10; wb.s_data = 32'ha0;
    tick();
    check_eq("full.s_ready1", 32'(wb.s_ready), 32'd1);
    check_port("full.prim1", 1'b1, 5'd1, 32'h100);
    wb.s_reg = 5'd11; wb.s_data = 32'ha1;
    tick();
    check_eq("full.s_ready2", 32'(wb.s_ready), 32'd0);
    check_eq("full.pending", 32'(wb.pending), 32'd1);
    wb.s_reg = 5'd12; wb.s_data = 32'ha2;
    tick();
    check_eq("full.s_ready3", 32'(wb.s_ready), 32'd0);
    check_port("full.prim3", 1'b1, 5'd1, 32'h100);
    wb.p_write = 1'b0;
    tick();
    check_port("full.pop10", 1'b1, 5'd10, 32'ha0);
    check_eq("full.reopen", 32'(wb.s_ready), 32'd1);
    tick();
    wb.s_valid = 1'b0;
    check_port("full.pop11", 1'b1, 5'd11, 32'ha1);
    check_eq("full.pend12", 32'(wb.pending), 32'd1);
    tick();
    check_port("full.pop12", 1'b1, 5'd12, 32'ha2);
    check_eq("full.empty", 32'(wb.pending), 32'd0);
    tick();
    check_eq("full.idle", 32'(wb.write), 32'd0);

    // Starvation under continuous primary traffic
    wb.p_write = 1'b1; wb.p_reg = 5'd2; wb.p_data = 32'h200;
    wb.s_valid = 1'b1; wb.s_reg = 5'd20; wb.s_data = 32'hb0;
    tick();
    wb.s_valid = 1'b0;
    check_eq("age.pending", 32'(wb.pending), 32'd1);
    check_eq("age.stall0", 32'(wb.p_stall), 32'd0);
`ifdef WB_ARB_AGING_EN
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("age.wait_stall", 32'(wb.p_stall), 32'd0);
      check_port("age.wait", 1'b1, 5'd2, 32'h200);
    end
    tick();
    check_eq("age.stall", 32'(wb.p_stall), 32'd1);
    tick();
    check_port("age.forced", 1'b1, 5'd20, 32'hb0);
    check_eq("age.unstall", 32'(wb.p_stall), 32'd0);
    check_eq("age.empty", 32'(wb.pending), 32'd0);
    tick();
    check_port("age.resume", 1'b1, 5'd2, 32'h200);
    idle();
`else
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("starve.stall", 32'(wb.p_stall), 32'd0);
      check_eq("starve.pending", 32'(wb.pending), 32'd1);
      check_port("starve.prim", 1'b1, 5'd2, 32'h200);
    end
    idle();
    tick();
    check_port("starve.drain", 1'b1, 5'd20, 32'hb0);
    check_eq("starve.empty", 32'(wb.pending), 32'd0);
`endif
    tick();

    // Reset while two entries are queued
    wb.p_write = 1'b1; wb.p_reg = 5'd5; wb.p_data = 32'h500;
    wb.s_valid = 1'b1; wb.s_reg = 5'd30; wb.s_data = 32'hc0;
    tick();
    wb.s_reg = 5'd31; wb.s_data = 32'hc1;
    tick();
    check_eq("rmid.full", 32'(wb.s_ready), 32'd0);
    idle();
    reset = 1'b1;
    #2;
    check_port("rmid.async", 1'b0, 5'd0, 32'h0);
    check_eq("rmid.pending", 32'(wb.pending), 32'd0);
    check_eq("rmid.s_ready", 32'(wb.s_ready), 32'd1);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rmid.nostale", 32'(wb.write), 32'd0);
      check_eq("rmid.empty", 32'(wb.pending), 32'd0);
    end
    wb.p_write = 1'b1; wb.p_reg = 5'd6; wb.p_data = 32'h66;
    tick();
    idle();
    check_port("rmid.new", 1'b1, 5'd6, 32'h66);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
